vdot_operand_sequencer: RTL and testbench
=========================================

// Module: vdot_operand_sequencer
// PURPOSE
//  Initiator side of the pipelined 16-lane fp16 dot-product engine. Accepts A then B
//  operands as a serial 16-bit word stream, assembles them into 256-bit vectors and
//  drives the engine's start/done protocol. Captures the result and overflow flag and
//  returns them on a valid/ready result port. Sits between the register-file/memory
//  streamer and the dot-product datapath.
// PARAMETERS
//  LANES    16  elements per vector (LANES*WIDTH must equal the engine width, 256)
//  WIDTH    16  bits per element (fp16)
//  TIMEOUT  32  max RUN cycles waiting for dp_done before aborting
// PORTS
//  Clk          in   1    single clock, all state on posedge
//  Rst          in   1    synchronous, active-high reset
//  in_data      in   16   operand word; word k lands in bits [16k+15:16k]
//  in_valid     in   1    in_data valid
//  in_ready     out  1    sequencer accepts a word (transfer when valid&ready)
//  flush        in   1    discard a partially loaded operand set
//  dp_A         out  256  vector A to engine, held stable while dp_start=1
//  dp_B         out  256  vector B to engine, held stable while dp_start=1
//  dp_start     out  1    engine start; held high until dp_done seen
//  dp_out       in   16   engine result
//  dp_V         in   1    engine overflow flag
//  dp_done      in   1    engine done (stays high while start high)
//  res_data     out  16   captured dot product
//  res_V        out  1    captured overflow
//  res_valid    out  1    result available; held until res_ready
//  res_ready    in   1    consumer accepts result
//  timeout_err  out  1    sticky: a RUN timed out; cleared only by Rst
//  busy         out  1    high in RUN, RESULT, GAP
// BEHAVIOUR
//  States: LOAD_A -> LOAD_B -> RUN -> RESULT -> GAP -> LOAD_A. Reset -> LOAD_A, idx=0.
//  Reset values: dp_A=dp_B=0, dp_start=0, res_data=0, res_V=0, res_valid=0,
//   timeout_err=0, idx=0, timer=0. in_ready/busy decoded from state (in_ready=1 after reset).
//  LOAD_A/LOAD_B: in_ready=1; each transfer writes lane idx, idx++. At idx=LANES-1 transfer:
//   idx wraps to 0, LOAD_A->LOAD_B, LOAD_B->RUN. dp_A/dp_B written only in these states.
//  RUN: dp_start=1 from the cycle after the last B word; timer counts from 0.
//   dp_done=1 sampled: res_data<=dp_out, res_V<=dp_V, res_valid<=1, -> RESULT.
//   timer==TIMEOUT-1 without dp_done: res_data<=16'h7E00 (qNaN), res_V<=1,
//   timeout_err<=1, res_valid<=1, -> RESULT. dp_done wins if both in same cycle.
//  RESULT: dp_start stays 1; res_valid held, res_data/res_V stable until res_ready.
//   On res_valid&res_ready: res_valid<=0, dp_start<=0, -> GAP.
//  GAP: exactly one cycle, dp_start=0, in_ready=0 (lets engine state clear). -> LOAD_A.
//  flush: in LOAD_A/LOAD_B -> LOAD_A, idx=0, dp_A/dp_B untouched; flush beats a
//   coincident word transfer (word discarded, in_ready still high that cycle).
//   Ignored in RUN/RESULT/GAP.
//  Rst mid-operation: all regs to reset values next edge; dp_start drops immediately.
//  Only one operation in flight; no overlap of loading with RUN.
// STRUCTURE
//  Shared package: state encoding (3-bit localparams), FP16_QNAN=16'h7E00,
//   VEC_W=LANES*WIDTH. Single module; lane write via indexed part-select, no sub-modules.
// TESTING
//  1) Reset; 16 words 3C00 (A) + 16 words 3C00 (B), real engine -> res_data=4C00, res_V=0,
//     dp_start high until res handshake, then 1-cycle GAP.
//  2) All-zero A/B -> res_data=0000, res_V=0; lane order check: A word0=4000, rest 0,
//     B word0=4200, rest 0 -> res_data=4600.
//  3) res_ready low 5 cycles after res_valid -> res_data/res_V stable, in_ready=0, busy=1.
//  4) Stub engine never asserts dp_done -> after 32 RUN cycles res_data=7E00, res_V=1,
//     timeout_err=1 and stays 1 over following good operations.
//  5) flush after 7 A words (and flush coincident with 16th B word) -> restart at lane 0;
//     subsequent full load gives correct result.
//  6) Rst asserted in RUN -> next cycle dp_start=0, res_valid=0, in_ready=1, idx=0.

Source files
------------

// File: rtl/vdot_operand_sequencer_pkg.sv
// Purpose : shared constants and state encoding for the vdot operand sequencer.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package vdot_operand_sequencer_pkg;

    localparam int LANES   = 16;
    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 32;
    localparam int VEC_W   = LANES * WIDTH;

    // Quiet NaN returned in place of a result when the engine never answers.
    localparam logic [15:0] FP16_QNAN = 16'h7E00;

    localparam logic [2:0] ST_LOAD_A = 3'd0;
    localparam logic [2:0] ST_LOAD_B = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_RESULT = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;

    typedef enum logic [2:0] {
        S_LOAD_A = ST_LOAD_A,
        S_LOAD_B = ST_LOAD_B,
        S_RUN    = ST_RUN,
        S_RESULT = ST_RESULT,
        S_GAP    = ST_GAP
    } state_t;

endpackage

// File: rtl/vdot_operand_sequencer.sv
// Purpose : assembles serial A/B operand words into vectors, runs the dot-product
//           engine start/done handshake and returns result + overflow on a valid/ready port.
// Latency : dp_start the cycle after the last B word; result one cycle after dp_done
//           (or after TIMEOUT RUN cycles); one GAP cycle after the result handshake.
// Backpressure: in_ready low outside LOAD_A/LOAD_B; res_valid and the result are held
//           until res_ready, and no new operand is accepted until then.
//
// Ports:
//   Clk, Rst                 clock, synchronous active-high reset
//   in_data/in_valid/in_ready operand word stream (A lanes 0..15, then B lanes 0..15)
//   flush                    drop a partially loaded operand set (load states only)
//   dp_A, dp_B, dp_start     operand vectors and start to the engine
//   dp_out, dp_V, dp_done    engine result, overflow and done
//   res_data/res_V/res_valid/res_ready  captured result port
//   timeout_err              sticky engine timeout indicator
//   busy                     operation in flight (RUN, RESULT, GAP)
module vdot_operand_sequencer
    import vdot_operand_sequencer_pkg::*;
#(
    parameter int LANES   = vdot_operand_sequencer_pkg::LANES,
    parameter int WIDTH   = vdot_operand_sequencer_pkg::WIDTH,
    parameter int TIMEOUT = vdot_operand_sequencer_pkg::TIMEOUT
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic [LANES*WIDTH-1:0]   dp_A,
    output logic [LANES*WIDTH-1:0]   dp_B,
    output logic                     dp_start,
    input  logic [WIDTH-1:0]         dp_out,
    input  logic                     dp_V,
    input  logic                     dp_done,
    output logic [WIDTH-1:0]         res_data,
    output logic                     res_V,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     timeout_err,
    output logic                     busy
);

    localparam int IW = $clog2(LANES);
    localparam int TW = $clog2(TIMEOUT);

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   idx;
    logic [TW-1:0]   timer;

    logic            xfer;
    logic            last_lane;
    logic            timer_exp;

    assign in_ready  = (state == S_LOAD_A) || (state == S_LOAD_B);
    assign busy      = (state == S_RUN) || (state == S_RESULT) || (state == S_GAP);
    assign xfer      = in_valid && in_ready;
    assign last_lane = (idx == IW'(LANES - 1));
    assign timer_exp = (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S_LOAD_A;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD_A: begin
                // flush outranks a coincident word
                if (flush)                   state_nxt = S_LOAD_A;
                else if (xfer && last_lane)  state_nxt = S_LOAD_B;
            end
            S_LOAD_B: begin
                if (flush)                   state_nxt = S_LOAD_A;
                else if (xfer && last_lane)  state_nxt = S_RUN;
            end
            S_RUN: begin
                if (dp_done || timer_exp)    state_nxt = S_RESULT;
            end
            S_RESULT: begin
                if (res_valid && res_ready)  state_nxt = S_GAP;
            end
            S_GAP:                           state_nxt = S_LOAD_A;
            default:                         state_nxt = S_LOAD_A;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            dp_A        <= '0;
            dp_B        <= '0;
            dp_start    <= 1'b0;
            res_data    <= '0;
            res_V       <= 1'b0;
            res_valid   <= 1'b0;
            timeout_err <= 1'b0;
            idx         <= '0;
            timer       <= '0;
        end else begin
            case (state)
                S_LOAD_A, S_LOAD_B: begin
                    if (flush) begin
                        // restart the operand set; vector contents are left as they are
                        idx <= '0;
                    end else if (xfer) begin
                        if (state == S_LOAD_A) dp_A[int'(idx)*WIDTH +: WIDTH] <= in_data;
                        else                   dp_B[int'(idx)*WIDTH +: WIDTH] <= in_data;
                        idx <= last_lane ? '0 : idx + 1'b1;
                        if ((state == S_LOAD_B) && last_lane) begin
                            dp_start <= 1'b1;
                            timer    <= '0;
                        end
                    end
                end
                S_RUN: begin
                    // a done arriving on the timeout cycle is still a good result
                    if (dp_done) begin
                        res_data  <= dp_out;
                        res_V     <= dp_V;
                        res_valid <= 1'b1;
                        timer     <= '0;
                    end else if (timer_exp) begin
                        res_data    <= FP16_QNAN;
                        res_V       <= 1'b1;
                        timeout_err <= 1'b1;
                        res_valid   <= 1'b1;
                        timer       <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_RESULT: begin
                    // dp_start stays up through RESULT so the engine keeps done asserted
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        dp_start  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vdot_operand_sequencer.sv
module tb_vdot_operand_sequencer;
    import vdot_operand_sequencer_pkg::*;

    logic              Clk = 1'b0;
    logic              Rst = 1'b1;
    logic [15:0]       in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              flush = 1'b0;
    logic [VEC_W-1:0]  dp_A;
    logic [VEC_W-1:0]  dp_B;
    logic              dp_start;
    logic [15:0]       dp_out = '0;
    logic              dp_V = 1'b0;
    logic              dp_done = 1'b0;
    logic [15:0]       res_data;
    logic              res_V;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic              timeout_err;
    logic              busy;

    int checks = 0;
    int errors = 0;

    // operand values as small integers; words on the bus are their fp16 encodings
    int a_vals [16];
    int b_vals [16];

    // engine model controls
    int eng_lat  = 2;
    bit eng_hang = 1'b0;
    bit eng_v    = 1'b0;
    int ecnt     = 0;
    bit gaps     = 1'b0;

    vdot_operand_sequencer dut (
        .Clk(Clk), .Rst(Rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .dp_A(dp_A), .dp_B(dp_B), .dp_start(dp_start),
        .dp_out(dp_out), .dp_V(dp_V), .dp_done(dp_done),
        .res_data(res_data), .res_V(res_V), .res_valid(res_valid), .res_ready(res_ready),
        .timeout_err(timeout_err), .busy(busy)
    );

    always #5 Clk = ~Clk;

    // exact fp16 encoding of a non-negative integer below 2048
    function automatic logic [15:0] int_to_fp16(input int n);
        int e;
        logic [4:0] ex;
        logic [9:0] mn;
        if (n == 0) return 16'h0000;
        e = 0;
        for (int i = 0; i < 11; i++) if ((n >> i) != 0) e = i;
        ex = 5'(15 + e);
        mn = 10'((n << (10 - e)) & 'h3FF);
        return {1'b0, ex, mn};
    endfunction

    // decode an integer-valued fp16 word
    function automatic int fp16_to_int(input logic [15:0] h);
        int e;
        int m;
        e = int'(h[14:10]);
        m = 1024 + int'(h[9:0]);
        if (e == 0) return 0;
        if (e >= 25) return m << (e - 25);
        return m >> (25 - e);
    endfunction

    function automatic int ref_dot();
        int s = 0;
        for (int i = 0; i < 16; i++) s += a_vals[i] * b_vals[i];
        return s;
    endfunction

    // behavioural engine: done after eng_lat+1 start cycles, holds done while start is high
    always @(posedge Clk) begin
        int s;
        if (!dp_start) begin
            ecnt    <= 0;
            dp_done <= 1'b0;
        end else if (!dp_done && !eng_hang) begin
            if (ecnt == eng_lat) begin
                s = 0;
                for (int k = 0; k < 16; k++)
                    s += fp16_to_int(dp_A[16*k +: 16]) * fp16_to_int(dp_B[16*k +: 16]);
                dp_out  <= int_to_fp16(s);
                dp_V    <= eng_v;
                dp_done <= 1'b1;
            end else begin
                ecnt <= ecnt + 1;
            end
        end
    end

    task automatic send_word(input logic [15:0] w);
        int n = 0;
        if (gaps && ($urandom_range(0, 3) == 0)) begin
            in_valid = 1'b0;
            @(posedge Clk); #1;
        end
        in_data  = w;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge Clk); #1;
            n++;
        end
        if (n >= 100) begin
            errors++;
            $display("FAIL send_word in_ready: got %b want 1", in_ready);
        end
        @(posedge Clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < 16; i++) send_word(int_to_fp16(a_vals[i]));
        for (int i = 0; i < 16; i++) send_word(int_to_fp16(b_vals[i]));
    endtask

    task automatic do_op(input string nm, input int hold, input bit expect_to,
                         input bit use_lit, input logic [15:0] lit);
        logic [15:0] exp_d;
        logic        exp_v;
        int          n;
        int          exp_n;
        load_all();
        checks++;
        if (dp_start !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s run_entry: got start=%b busy=%b in_ready=%b want 1 1 0",
                     nm, dp_start, busy, in_ready);
        end
        exp_d = expect_to ? 16'h7E00 : (use_lit ? lit : int_to_fp16(ref_dot()));
        exp_v = expect_to ? 1'b1 : eng_v;
        exp_n = expect_to ? 32 : eng_lat + 2;
        n = 0;
        while (res_valid !== 1'b1 && n < 200) begin
            @(posedge Clk); #1;
            n++;
        end
        checks++;
        if (n != exp_n) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles want %0d", nm, n, exp_n);
        end
        checks++;
        if (res_data !== exp_d) begin
            errors++;
            $display("FAIL %s res_data: got %h want %h", nm, res_data, exp_d);
        end
        checks++;
        if (res_V !== exp_v) begin
            errors++;
            $display("FAIL %s res_V: got %b want %b", nm, res_V, exp_v);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge Clk); #1;
            checks++;
            if (res_valid !== 1'b1 || res_data !== exp_d || res_V !== exp_v ||
                in_ready !== 1'b0 || busy !== 1'b1 || dp_start !== 1'b1) begin
                errors++;
                $display("FAIL %s hold%0d: got vld=%b d=%h v=%b rdy=%b busy=%b start=%b want 1 %h %b 0 1 1",
                         nm, h, res_valid, res_data, res_V, in_ready, busy, dp_start, exp_d, exp_v);
            end
        end
        res_ready = 1'b1;
        @(posedge Clk); #1;
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || dp_start !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s gap: got vld=%b start=%b rdy=%b busy=%b want 0 0 0 1",
                     nm, res_valid, dp_start, in_ready, busy);
        end
        @(posedge Clk); #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s back_to_load: got rdy=%b busy=%b want 1 0", nm, in_ready, busy);
        end
    endtask

    task automatic randomize_vals();
        for (int i = 0; i < 16; i++) begin
            a_vals[i] = int'($urandom_range(0, 3));
            b_vals[i] = int'($urandom_range(0, 3));
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (dp_start !== 1'b0 || res_valid !== 1'b0 || res_data !== 16'h0 || res_V !== 1'b0 ||
            timeout_err !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
            dp_A !== '0 || dp_B !== '0) begin
            errors++;
            $display("FAIL reset: got start=%b vld=%b d=%h v=%b to=%b rdy=%b busy=%b A0=%h B0=%h want 0 0 0000 0 0 1 0 0 0",
                     dp_start, res_valid, res_data, res_V, timeout_err, in_ready, busy,
                     dp_A[15:0], dp_B[15:0]);
        end
        Rst = 1'b0;
    endtask

    task automatic test_ones();
        for (int i = 0; i < 16; i++) begin a_vals[i] = 1; b_vals[i] = 1; end
        eng_lat = 2; eng_v = 1'b0;
        do_op("ones", 0, 1'b0, 1'b1, 16'h4C00);
    endtask

    task automatic test_zero_and_lanes();
        for (int i = 0; i < 16; i++) begin a_vals[i] = 0; b_vals[i] = 0; end
        eng_lat = 0;
        do_op("zeros", 0, 1'b0, 1'b1, 16'h0000);
        a_vals[0] = 2; b_vals[0] = 3;
        eng_lat = 4;
        do_op("lane0", 1, 1'b0, 1'b1, 16'h4600);
    endtask

    task automatic test_backpressure();
        randomize_vals();
        eng_lat = 1; eng_v = 1'b1;
        do_op("backpressure", 5, 1'b0, 1'b0, 16'h0);
        eng_v = 1'b0;
    endtask

    task automatic test_timeout();
        randomize_vals();
        eng_hang = 1'b1;
        do_op("timeout", 2, 1'b1, 1'b0, 16'h0);
        eng_hang = 1'b0;
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err set: got %b want 1", timeout_err);
        end
        for (int r = 0; r < 2; r++) begin
            randomize_vals();
            eng_lat = int'($urandom_range(0, 3));
            do_op("after_timeout", 0, 1'b0, 1'b0, 16'h0);
            checks++;
            if (timeout_err !== 1'b1) begin
                errors++;
                $display("FAIL timeout_err sticky: got %b want 1", timeout_err);
            end
        end
    endtask

    task automatic test_flush();
        logic [15:0] prev_b15;
        // partial A load then flush
        for (int i = 0; i < 7; i++) send_word(16'h5555);
        flush = 1'b1;
        @(posedge Clk); #1;
        flush = 1'b0;
        randomize_vals();
        eng_lat = 2;
        do_op("flush_a7", 0, 1'b0, 1'b0, 16'h0);
        // flush coincident with the 16th B word
        prev_b15 = int_to_fp16(b_vals[15]);
        randomize_vals();
        for (int i = 0; i < 16; i++) send_word(int_to_fp16(a_vals[i]));
        for (int i = 0; i < 15; i++) send_word(int_to_fp16(b_vals[i]));
        in_data = 16'hFFFF; in_valid = 1'b1; flush = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_b16 in_ready: got %b want 1", in_ready);
        end
        @(posedge Clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || dp_start !== 1'b0 || dp_B[255:240] !== prev_b15) begin
            errors++;
            $display("FAIL flush_b16 state: got rdy=%b busy=%b start=%b b15=%h want 1 0 0 %h",
                     in_ready, busy, dp_start, dp_B[255:240], prev_b15);
        end
        randomize_vals();
        do_op("flush_b16", 0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_reset_in_run();
        randomize_vals();
        eng_hang = 1'b1;
        load_all();
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b1;
        @(posedge Clk); #1;
        checks++;
        if (dp_start !== 1'b0 || res_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
            timeout_err !== 1'b0 || dp_A !== '0 || dp_B !== '0) begin
            errors++;
            $display("FAIL reset_in_run: got start=%b vld=%b rdy=%b busy=%b to=%b A0=%h want 0 0 1 0 0 0",
                     dp_start, res_valid, in_ready, busy, timeout_err, dp_A[15:0]);
        end
        Rst = 1'b0;
        eng_hang = 1'b0;
        @(posedge Clk); #1;
        randomize_vals();
        do_op("after_reset", 0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_back_to_back();
        gaps = 1'b1;
        for (int r = 0; r < 6; r++) begin
            randomize_vals();
            eng_lat = int'($urandom_range(0, 4));
            eng_v   = 1'($urandom_range(0, 1));
            do_op("random", int'($urandom_range(0, 3)), 1'b0, 1'b0, 16'h0);
        end
        gaps = 1'b0;
    endtask

    initial begin
        @(posedge Clk); #1;
        test_reset();
        test_ones();
        test_zero_and_lanes();
        test_backpressure();
        test_timeout();
        test_flush();
        test_reset_in_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
